seq_signed_divider: RTL and testbench
=====================================

Name: seq_signed_divider

Overview:
- Multi-cycle signed fixed-point (integer-scaled) divider; the inverse operation to the team's combinational Booth multiplier.
- Computes Quotient = Dividend / Divisor and Remainder in two's complement, using truncating division toward zero.
- Uses a radix-2 restoring algorithm on magnitudes, one quotient bit per clock, followed by a sign-fix step.
- Sits beside the multiplier in the fixed-point arithmetic library. It is used where area matters more than latency.

Parameters:
- Operand_Width, 8, width of Dividend, Divisor, Quotient and Remainder (two's complement); legal range 4..32.
- Count_Width, $clog2(Operand_Width+1), width of the internal iteration counter; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only while in IDLE.
- Dividend  input  Operand_Width  signed numerator; captured on an accepted start.
- Divisor  input  Operand_Width  signed denominator; captured on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- Quotient  output  Operand_Width  signed quotient; held until the next done.
- Remainder  output  Operand_Width  signed remainder; its sign equals the Dividend's sign, or it is zero.
- div_by_zero  output  1  set when the Divisor was 0; held with results.
- overflow  output  1  set only for most-negative / -1; held with results.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, div_by_zero, overflow = 0; Quotient and Remainder = 0; counter and internal registers = 0. A reset during DIV or FIX aborts the operation, and no done is produced.
- States:
  - IDLE -> DIV on start & Divisor!=0.
  - IDLE -> ZERO on start & Divisor==0.
  - DIV -> DIV while counter != 0.
  - DIV -> FIX when the last iteration completes.
  - FIX -> IDLE, with done=1 in the following cycle.
  - ZERO -> IDLE, with done=1 in the following cycle.
- Accepting a start (IDLE): capture the sign of each operand. Capture the magnitudes |Dividend| and |Divisor| as Operand_Width-bit unsigned values; |most-negative| = 2^(W-1) fits unsigned. Clear the partial remainder (W+1 bits) and load counter = W.
- DIV, each cycle:
  - Shift {rem, quo} left by 1, bringing in the MSB of the dividend magnitude.
  - Trial = rem - |Divisor|, computed W+1 bits wide.
  - If the trial is non-negative: rem = trial and the new quo bit = 1. Otherwise rem is kept and the quo bit = 0.
  - Decrement the counter. DIV lasts exactly W cycles.
- FIX (1 cycle):
  - Quotient = neg(quo) when the operand signs differ, else quo.
  - Remainder = neg(rem) when the Dividend is negative, else rem.
  - overflow = (Dividend == most-negative) & (Divisor == -1). In that case Quotient is the wrapped value, most-negative.
- ZERO (1 cycle): Quotient = all ones, Remainder = Dividend, div_by_zero = 1, overflow = 0.
- Latency:
  - Normal operation: start sampled in cycle 0, done in cycle W+2, so 10 cycles for W=8.
  - Divide by zero: done in cycle 2.
  - busy=1 in cycles 1 through W+1 (1 for divide by zero); busy=0 in the done cycle.
- start while busy is ignored. It is neither queued nor allowed to corrupt state.
- start in the done cycle is accepted, because the state is IDLE. Outputs keep their old values until the next done.
- div_by_zero and overflow update only when done is asserted.
- Operands are never re-sampled after acceptance. Input changes during busy have no effect.

Decomposition:
- Package seq_div_pkg:
  - State enum IDLE/DIV/FIX/ZERO, 2-bit encoding.
  - Functions: magnitude-of-signed and two's-complement-negate, both parameterised by width.
- Sub-module udiv_step: combinational single iteration.
  - Inputs: rem, the incoming bit, and the divisor magnitude.
  - Outputs: next rem and the quotient bit.
  - The FSM and registers stay in the top module.

Test Plan:
- 100 / 7 -> done at cycle 10; Quotient=14, Remainder=2; flags 0.
- -100 / 7 -> Quotient=-14 (0xF2), Remainder=-2 (0xFE). Also 100 / -7 -> Quotient=0xF2, Remainder=2.
- -128 / -1 -> Quotient=0x80, Remainder=0, overflow=1. Also -128 / 1 -> Quotient=0x80, overflow=0.
- 5 / 0 -> done at cycle 2, Quotient=0xFF, Remainder=5, div_by_zero=1. Then 6 / 3 -> Quotient=2, div_by_zero cleared.
- Issue 50 / 5; pulse start with 9 / 3 at cycle 4 -> that start is ignored, and the result is Quotient=10, Remainder=0. Back-to-back start in the done cycle -> the next result follows 10 cycles later.
- Drop rst_n at cycle 5 of an operation -> all outputs 0 immediately and no done. After release, 7 / 2 -> Quotient=3, Remainder=1. Also run a random sweep against a reference model (truncating division).

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Helpers work on a 32-bit container; callers sign- or zero-extend
// narrower operands in and keep the low bits they need.
package seq_div_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } state_e;

  // Two's-complement negate; the low W bits are the W-bit negation.
  function automatic logic [MAX_W-1:0] neg_tc(input logic [MAX_W-1:0] v);
    return ~v + MAX_W'(1);
  endfunction

  // Magnitude of a sign-extended value; |most-negative| comes out unsigned.
  function automatic logic [MAX_W-1:0] mag_s(input logic [MAX_W-1:0] v);
    return v[MAX_W-1] ? neg_tc(v) : v;
  endfunction

endpackage

// File: rtl/udiv_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module udiv_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // Shift in the next dividend bit and keep the trial difference if non-negative.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {2'b00, dvs_i};
    q_o     = ~trial[W+1];
    rem_o   = q_o ? trial[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: restoring division on magnitudes, one
// quotient bit per clock, then a one-cycle sign-fix. Truncates toward zero.
module seq_signed_divider
  import seq_div_pkg::*;
#(
  parameter  int Operand_Width = 8,
  localparam int Count_Width   = $clog2(Operand_Width + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [Operand_Width-1:0] Dividend,
  input  logic [Operand_Width-1:0] Divisor,
  output logic                     busy,
  output logic                     done,
  output logic [Operand_Width-1:0] Quotient,
  output logic [Operand_Width-1:0] Remainder,
  output logic                     div_by_zero,
  output logic                     overflow
);

  localparam int W = Operand_Width;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  state_e               state_q, state_d;
  logic                 sign_dd_q, sign_dd_d;
  logic                 sign_dv_q, sign_dv_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [W-1:0]         quo_q, quo_d;
  logic [W-1:0]         dvs_q, dvs_d;
  logic [W:0]           rem_q, rem_d;
  logic [Count_Width-1:0] cnt_q, cnt_d;
  logic [W-1:0]         quotient_q, quotient_d;
  logic [W-1:0]         remainder_q, remainder_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  logic                 ovf_q, ovf_d;

  logic [W:0]           step_rem;
  logic                 step_bit;
  logic [MAX_W-1:0]     dvd_mag, dvs_mag, quo_neg, rem_neg;

  udiv_step #(.W(W)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[W-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  // Magnitudes of the live operands and negations of the working registers.
  always_comb begin
    dvd_mag = mag_s(MAX_W'($signed(Dividend)));
    dvs_mag = mag_s(MAX_W'($signed(Divisor)));
    quo_neg = neg_tc(MAX_W'(quo_q));
    rem_neg = neg_tc(MAX_W'(rem_q[W-1:0]));
  end

  // Next-state and datapath control for the divider FSM.
  // quo_q starts as |Dividend| and shifts out its MSB while quotient bits enter
  // at the LSB; in ZERO it still holds |Dividend|, which rebuilds the Remainder.
  always_comb begin
    state_d     = state_q;
    sign_dd_d   = sign_dd_q;
    sign_dv_d   = sign_dv_q;
    ovf_pend_d  = ovf_pend_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_dd_d  = Dividend[W-1];
          sign_dv_d  = Divisor[W-1];
          quo_d      = dvd_mag[W-1:0];
          dvs_d      = dvs_mag[W-1:0];
          rem_d      = '0;
          cnt_d      = Count_Width'(W);
          ovf_pend_d = (Dividend == MOST_NEG) && (Divisor == '1);
          busy_d     = 1'b1;
          state_d    = (Divisor == '0) ? ZERO : DIV;
        end
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = {quo_q[W-2:0], step_bit};
        cnt_d = cnt_q - Count_Width'(1);
        if (cnt_q == Count_Width'(1)) state_d = FIX;
      end
      FIX: begin
        quotient_d  = (sign_dd_q ^ sign_dv_q) ? quo_neg[W-1:0] : quo_q;
        remainder_d = sign_dd_q ? rem_neg[W-1:0] : rem_q[W-1:0];
        ovf_d       = ovf_pend_q;
        dbz_d       = 1'b0;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      ZERO: begin
        quotient_d  = '1;
        remainder_d = sign_dd_q ? quo_neg[W-1:0] : quo_q;
        ovf_d       = 1'b0;
        dbz_d       = 1'b1;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_dd_q   <= 1'b0;
      sign_dv_q   <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_dd_q   <= sign_dd_d;
      sign_dv_q   <= sign_dv_d;
      ovf_pend_q  <= ovf_pend_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Quotient    = quotient_q;
  assign Remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Randomised and directed bench for seq_signed_divider against an
// integer-arithmetic reference (truncating division toward zero).
module tb_seq_signed_divider;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         div_by_zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int hold_q = 0;
  int hold_r = 0;
  int hold_z = 0;
  int hold_o = 0;

  seq_signed_divider #(.Operand_Width(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .busy        (busy),
    .done        (done),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer division with the divider's special cases.
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r,
                                  output int dz, output int ov);
    dz = 0;
    ov = 0;
    if (b == 0) begin
      q  = -1;
      r  = a;
      dz = 1;
    end else if (a == MINV && b == -1) begin
      q  = MINV;
      r  = 0;
      ov = 1;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one operation (caller is away from the clock edge) and check it.
  // inject > 0 pulses a stray start with other operands in that cycle.
  task automatic run_op(input int a, input int b, input int inject);
    int q, r, dz, ov, n, exp_lat;
    bit got_done;
    ref_div(a, b, q, r, dz, ov);
    exp_lat  = (b == 0) ? 2 : W + 2;
    Dividend = W'(a);
    Divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    n        = 0;
    got_done = 1'b0;
    while (!got_done && n < 40) begin
      start = 1'b0;
      check("busy_during_op", busy, 1);
      check("quotient_held", Quotient, hold_q);
      check("remainder_held", Remainder, hold_r);
      if (inject > 0 && n + 1 == inject) begin
        start    = 1'b1;
        Dividend = W'(9);
        Divisor  = W'(3);
      end
      @(posedge clk);
      #1;
      n++;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    if (!got_done) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", n + 1, exp_lat);
      check("quotient", Quotient, q & MASK);
      check("remainder", Remainder, r & MASK);
      check("div_by_zero", div_by_zero, dz);
      check("overflow", overflow, ov);
      check("busy_in_done", busy, 0);
      hold_q = q & MASK;
      hold_r = r & MASK;
      hold_z = dz;
      hold_o = ov;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;
    rst_n    = 1'b0;
    start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", Quotient, 0);
    check("reset_remainder", Remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    check("reset_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(100, 7, 0);
    run_op(-100, 7, 0);
    run_op(100, -7, 0);
    run_op(-128, -1, 0);
    run_op(-128, 1, 0);
    run_op(5, 0, 0);
    run_op(6, 3, 0);
    run_op(50, 5, 4);
    run_op(-128, 0, 0);
    run_op(127, -128, 0);

    // Done pulses for one cycle only and results are held afterwards.
    @(posedge clk);
    #1;
    check("done_single_pulse", done, 0);
    check("quotient_after_done", Quotient, hold_q);
    check("dbz_after_done", div_by_zero, hold_z);

    // Abort an operation with reset in its fifth cycle.
    Dividend = W'(100);
    Divisor  = W'(7);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", Quotient, 0);
    check("abort_remainder", Remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    check("abort_ovf", overflow, 0);
    hold_q = 0;
    hold_r = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      check("no_done_after_abort", done, 0);
    end
    run_op(7, 2, 0);

    // Random sweep, mixing back-to-back starts with idle gaps.
    for (int i = 0; i < 150; i++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = -1;
        2: a = MINV;
        3: begin a = MINV; b = -1; end
        default: ;
      endcase
      run_op(a, b, 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
